// File: rtl/mem_access_stage_pkg.sv
// Shared LC-3b MEM-stage types: access FSM states and write byte-lane encodings.
package lc3b_types;

  localparam int LC3B_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IND_RD = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } lc3b_mem_state_t;

  localparam logic [1:0] BE_NONE = 2'b00;
  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory port between the MEM stage (master) and the data memory (slave).
interface mem_access_stage_if;
  import lc3b_types::*;

  logic [LC3B_WIDTH-1:0] dmem_address;
  logic                  dmem_read;
  logic                  dmem_write;
  logic [1:0]            dmem_byte_enable;
  logic [LC3B_WIDTH-1:0] dmem_wdata;
  logic [LC3B_WIDTH-1:0] dmem_rdata;
  logic                  dmem_resp;

  modport master (
    output dmem_address, dmem_read, dmem_write, dmem_byte_enable, dmem_wdata,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_address, dmem_read, dmem_write, dmem_byte_enable, dmem_wdata,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/mem_access_stage_ctrl.sv
// MEM-stage access FSM: sequences the pointer read and final access, holds in DONE until the pipe advances.
module mem_access_ctrl
  import lc3b_types::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_read_in,
  input  logic            mem_write_in,
  input  logic            indirect_in,
  input  logic            dmem_resp,
  input  logic            pipe_advance,
  output lc3b_mem_state_t state,
  output logic            dmem_read,
  output logic            dmem_write,
  output logic            mem_stall,
  output logic            ind_load,
  output logic            mdr_load,
  output logic            mar_load
);

  lc3b_mem_state_t state_reg;
  lc3b_mem_state_t state_next;
  logic            pending;

  assign pending = mem_read_in | mem_write_in;
  assign state   = state_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    mem_stall  = 1'b0;
    ind_load   = 1'b0;
    mdr_load   = 1'b0;
    mar_load   = 1'b0;

    unique case (state_reg)
      IDLE: begin
        mem_stall = pending;
        if (pending) begin
          state_next = indirect_in ? IND_RD : ACCESS;
        end
      end
      IND_RD: begin
        dmem_read = 1'b1;
        mem_stall = 1'b1;
        if (dmem_resp) begin
          ind_load   = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        dmem_read  = mem_read_in;
        dmem_write = mem_write_in;
        mem_stall  = 1'b1;
        if (dmem_resp) begin
          mdr_load   = mem_read_in;
          mar_load   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        // Holding here keeps a stalled-by-others instruction from issuing twice.
        if (pipe_advance) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (reset) begin
      state_next = IDLE;
      dmem_read  = 1'b0;
      dmem_write = 1'b0;
      mem_stall  = 1'b0;
      ind_load   = 1'b0;
      mdr_load   = 1'b0;
      mar_load   = 1'b0;
    end
  end

endmodule

// File: rtl/register.sv
// Generic loadable register with synchronous active-high clear.
module register #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// LC-3b MEM stage: drives the data-memory port for loads/stores (incl. LDI/STI) and registers MDR/MAR lsb for WB.
module mem_access_stage
  import lc3b_types::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_read_in,
  input  logic               mem_write_in,
  input  logic               indirect_in,
  input  logic               byte_op_in,
  input  logic [WIDTH-1:0]   address_in,
  input  logic [WIDTH-1:0]   store_data_in,
  input  logic               pipe_advance,
  mem_access_stage_if.master dmem,
  output logic               mem_stall,
  output logic [WIDTH-1:0]   mdr_out,
  output logic               mar_lsb_out
);

  lc3b_mem_state_t  state;
  logic             ctrl_read;
  logic             ctrl_write;
  logic             ind_load;
  logic             mdr_load;
  logic             mar_load;
  logic [WIDTH-1:0] ind_addr;
  logic [WIDTH-1:0] eff_addr;
  logic [WIDTH-1:0] byte_wdata;

  mem_access_ctrl u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .mem_read_in  (mem_read_in),
    .mem_write_in (mem_write_in),
    .indirect_in  (indirect_in),
    .dmem_resp    (dmem.dmem_resp),
    .pipe_advance (pipe_advance),
    .state        (state),
    .dmem_read    (ctrl_read),
    .dmem_write   (ctrl_write),
    .mem_stall    (mem_stall),
    .ind_load     (ind_load),
    .mdr_load     (mdr_load),
    .mar_load     (mar_load)
  );

  // Pointer fetched by the first access of LDI/STI.
  register #(.WIDTH(WIDTH)) u_ind_addr (
    .clk (clk), .reset (reset), .load (ind_load), .d (dmem.dmem_rdata), .q (ind_addr)
  );

  register #(.WIDTH(WIDTH)) u_mdr (
    .clk (clk), .reset (reset), .load (mdr_load), .d (dmem.dmem_rdata), .q (mdr_out)
  );

  register #(.WIDTH(1)) u_mar_lsb (
    .clk (clk), .reset (reset), .load (mar_load), .d (eff_addr[0]), .q (mar_lsb_out)
  );

  assign eff_addr = indirect_in ? ind_addr : address_in;

  // Stores of a byte put the same byte on both lanes; byte_enable picks the lane.
  for (genvar gi = 0; gi < WIDTH / 8; gi++) begin : g_byte_rep
    assign byte_wdata[gi*8 +: 8] = store_data_in[7:0];
  end

  assign dmem.dmem_read  = ctrl_read;
  assign dmem.dmem_write = ctrl_write;

  always_comb begin
    dmem.dmem_address     = {address_in[WIDTH-1:1], 1'b0};
    dmem.dmem_byte_enable = BE_NONE;
    dmem.dmem_wdata       = store_data_in;
    if (state == ACCESS && !reset) begin
      if (byte_op_in) begin
        dmem.dmem_address     = eff_addr;
        dmem.dmem_byte_enable = eff_addr[0] ? BE_HI : BE_LO;
        dmem.dmem_wdata       = byte_wdata;
      end else begin
        dmem.dmem_address     = {eff_addr[WIDTH-1:1], 1'b0};
        dmem.dmem_byte_enable = BE_WORD;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: LDR, STB, LDI, ADD, DONE hold and mid-sequence reset.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset, mem_read_in, mem_write_in, indirect_in, byte_op_in, pipe_advance;
  logic [15:0] address_in, store_data_in;
  logic        mem_stall, mar_lsb_out;
  logic [15:0] mdr_out;
  int          total = 0;
  int          bad = 0;

  mem_access_stage_if bus ();

  mem_access_stage #(.WIDTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_read_in   (mem_read_in),
    .mem_write_in  (mem_write_in),
    .indirect_in   (indirect_in),
    .byte_op_in    (byte_op_in),
    .address_in    (address_in),
    .store_data_in (store_data_in),
    .pipe_advance  (pipe_advance),
    .dmem          (bus),
    .mem_stall     (mem_stall),
    .mdr_out       (mdr_out),
    .mar_lsb_out   (mar_lsb_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0; indirect_in = 1'b0;
    byte_op_in = 1'b0; pipe_advance = 1'b0; address_in = 16'h0000; store_data_in = 16'h0000;
    bus.dmem_rdata = 16'h0000; bus.dmem_resp = 1'b0;
    step(); step();
    chk("rst_stall", {15'd0, mem_stall}, 16'd0);
    chk("rst_read", {15'd0, bus.dmem_read}, 16'd0);
    chk("rst_write", {15'd0, bus.dmem_write}, 16'd0);
    chk("rst_mdr", mdr_out, 16'h0000);
    chk("rst_mar", {15'd0, mar_lsb_out}, 16'd0);

    // LDR x3004, memory answers on the second ACCESS cycle
    reset = 1'b0; address_in = 16'h3004; #1;
    chk("ldr_idle_stall", {15'd0, mem_stall}, 16'd1);
    chk("ldr_idle_noreq", {15'd0, bus.dmem_read}, 16'd0);
    step();
    chk("ldr_read", {15'd0, bus.dmem_read}, 16'd1);
    chk("ldr_addr", bus.dmem_address, 16'h3004);
    chk("ldr_be", {14'd0, bus.dmem_byte_enable}, 16'h0003);
    chk("ldr_stall", {15'd0, mem_stall}, 16'd1);
    step();
    chk("ldr_wait_read", {15'd0, bus.dmem_read}, 16'd1);
    chk("ldr_wait_stall", {15'd0, mem_stall}, 16'd1);
    bus.dmem_rdata = 16'hBEEF; bus.dmem_resp = 1'b1;
    step();
    bus.dmem_resp = 1'b0; #1;
    chk("ldr_done_stall", {15'd0, mem_stall}, 16'd0);
    chk("ldr_done_read", {15'd0, bus.dmem_read}, 16'd0);
    chk("ldr_mdr", mdr_out, 16'hBEEF);
    chk("ldr_mar", {15'd0, mar_lsb_out}, 16'd0);
    pipe_advance = 1'b1;
    step();

    // STB x2001 <- xA5
    mem_read_in = 1'b0; mem_write_in = 1'b1; byte_op_in = 1'b1;
    address_in = 16'h2001; store_data_in = 16'h00A5; pipe_advance = 1'b0; #1;
    chk("stb_idle_stall", {15'd0, mem_stall}, 16'd1);
    chk("stb_idle_nowr", {15'd0, bus.dmem_write}, 16'd0);
    step();
    chk("stb_write", {15'd0, bus.dmem_write}, 16'd1);
    chk("stb_noread", {15'd0, bus.dmem_read}, 16'd0);
    chk("stb_addr", bus.dmem_address, 16'h2001);
    chk("stb_be", {14'd0, bus.dmem_byte_enable}, 16'h0002);
    chk("stb_wdata", bus.dmem_wdata, 16'hA5A5);
    bus.dmem_resp = 1'b1;
    step();
    bus.dmem_resp = 1'b0; #1;
    chk("stb_done_nowr", {15'd0, bus.dmem_write}, 16'd0);
    chk("stb_done_be", {14'd0, bus.dmem_byte_enable}, 16'h0000);
    chk("stb_mdr_kept", mdr_out, 16'hBEEF);
    chk("stb_mar", {15'd0, mar_lsb_out}, 16'd1);
    pipe_advance = 1'b1;
    step();

    // LDI x4000: mem[x4000]=x5001, mem[x5000]=x1234
    mem_write_in = 1'b0; byte_op_in = 1'b0; mem_read_in = 1'b1; indirect_in = 1'b1;
    address_in = 16'h4000; pipe_advance = 1'b0; #1;
    chk("ldi_idle_stall", {15'd0, mem_stall}, 16'd1);
    step();
    chk("ldi_ptr_read", {15'd0, bus.dmem_read}, 16'd1);
    chk("ldi_ptr_addr", bus.dmem_address, 16'h4000);
    chk("ldi_ptr_be", {14'd0, bus.dmem_byte_enable}, 16'h0000);
    chk("ldi_ptr_stall", {15'd0, mem_stall}, 16'd1);
    bus.dmem_rdata = 16'h5001; bus.dmem_resp = 1'b1;
    step();
    bus.dmem_resp = 1'b0; #1;
    chk("ldi_acc_read", {15'd0, bus.dmem_read}, 16'd1);
    chk("ldi_acc_addr", bus.dmem_address, 16'h5000);
    chk("ldi_acc_be", {14'd0, bus.dmem_byte_enable}, 16'h0003);
    chk("ldi_acc_stall", {15'd0, mem_stall}, 16'd1);
    bus.dmem_rdata = 16'h1234; bus.dmem_resp = 1'b1;
    step();
    bus.dmem_resp = 1'b0; #1;
    chk("ldi_mdr", mdr_out, 16'h1234);
    chk("ldi_mar", {15'd0, mar_lsb_out}, 16'd1);
    chk("ldi_done_stall", {15'd0, mem_stall}, 16'd0);
    pipe_advance = 1'b1;
    step();

    // ADD: no memory op while the pipe flows
    mem_read_in = 1'b0; indirect_in = 1'b0; address_in = 16'h0F0F;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("add_stall_%0d", i), {15'd0, mem_stall}, 16'd0);
      chk($sformatf("add_req_%0d", i), {14'd0, bus.dmem_read, bus.dmem_write}, 16'd0);
      chk($sformatf("add_mdr_%0d", i), mdr_out, 16'h1234);
      step();
    end

    // LDB x3007 then hold in DONE for 3 cycles
    mem_read_in = 1'b1; byte_op_in = 1'b1; address_in = 16'h3007; pipe_advance = 1'b0;
    step();
    chk("ldb_addr", bus.dmem_address, 16'h3007);
    chk("ldb_be", {14'd0, bus.dmem_byte_enable}, 16'h0002);
    bus.dmem_rdata = 16'hCAFE; bus.dmem_resp = 1'b1;
    step();
    bus.dmem_resp = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("hold_stall_%0d", i), {15'd0, mem_stall}, 16'd0);
      chk($sformatf("hold_read_%0d", i), {15'd0, bus.dmem_read}, 16'd0);
      chk($sformatf("hold_mdr_%0d", i), mdr_out, 16'hCAFE);
      step();
    end
    chk("hold_mar", {15'd0, mar_lsb_out}, 16'd1);
    pipe_advance = 1'b1;
    step();
    chk("hold_back_idle", {15'd0, mem_stall}, 16'd1);
    mem_read_in = 1'b0; byte_op_in = 1'b0; #1;
    chk("hold_idle_quiet", {15'd0, mem_stall}, 16'd0);

    // Reset while the LDI pointer read is outstanding
    pipe_advance = 1'b0; mem_read_in = 1'b1; indirect_in = 1'b1; address_in = 16'h4000;
    step();
    chk("rmid_ptr_read", {15'd0, bus.dmem_read}, 16'd1);
    reset = 1'b1; #1;
    chk("rmid_in_rst_read", {15'd0, bus.dmem_read}, 16'd0);
    chk("rmid_in_rst_stall", {15'd0, mem_stall}, 16'd0);
    step();
    reset = 1'b0; mem_read_in = 1'b0; indirect_in = 1'b0;
    bus.dmem_rdata = 16'hFFFF; bus.dmem_resp = 1'b1; #1;
    chk("rmid_mdr", mdr_out, 16'h0000);
    chk("rmid_mar", {15'd0, mar_lsb_out}, 16'd0);
    chk("rmid_req", {14'd0, bus.dmem_read, bus.dmem_write}, 16'd0);
    step();
    bus.dmem_resp = 1'b0; #1;
    chk("late_resp_mdr", mdr_out, 16'h0000);
    chk("late_resp_mar", {15'd0, mar_lsb_out}, 16'd0);
    chk("late_resp_req", {14'd0, bus.dmem_read, bus.dmem_write}, 16'd0);
    chk("late_resp_stall", {15'd0, mem_stall}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
